twowire_dtm_cmd_engine: RTL and testbench

// Command/payload engine directly downstream of the DTM serial comms unit. Decodes the
// 4-bit command strobed on cmd_vld and counts payload bits, asserting cmd_payload_end
// on the last bit. Shifts write data in and read data out, LSB first. Owns the

---
 rtl/twowire_dtm_cmd_engine_pkg.sv | 33 +++
 rtl/twowire_dtm_cmd_engine_if.sv | 15 +
 rtl/twowire_dtm_cmd_engine_bus_master.sv | 72 +++++++
 rtl/twowire_dtm_cmd_engine.sv | 98 +++++++++
 tb/tb_twowire_dtm_cmd_engine.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/twowire_dtm_cmd_engine_pkg.sv
// twowire_dtm_cmd_engine_pkg: command codes, CSR layout and shared types for the DTM command engine
package twowire_dtm_cmd_engine_pkg;
   localparam logic [3:0] CMD_DISCONNECT = 4'h0;
   localparam logic [3:0] CMD_R_IDCODE   = 4'h1;
   localparam logic [3:0] CMD_R_CSR      = 4'h2;
   localparam logic [3:0] CMD_W_CSR      = 4'h3;
   localparam logic [3:0] CMD_R_ADDR     = 4'h4;
   localparam logic [3:0] CMD_W_ADDR     = 4'h5;
   localparam logic [3:0] CMD_W_DATA     = 4'h6;
   localparam logic [3:0] CMD_R_DATA     = 4'h7;

   localparam int CSR_BUSYERR = 0;
   localparam int CSR_BUSERR  = 1;
   localparam int CSR_BUSY    = 2;
   localparam int CSR_AINCR   = 3;
   localparam logic [3:0] CSR_VERSION = 4'h1;

   localparam int XFER_BITS = 32;
   localparam int DISC_BITS = 8;

   typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_t;
   typedef enum logic {BUS_IDLE, BUS_WAIT} bus_state_t;

   function automatic logic [31:0] csr_pack(input logic busyerr, input logic buserr,
                                            input logic busy, input logic aincr);
      csr_pack = '0;
      csr_pack[31:28] = CSR_VERSION;
      csr_pack[CSR_BUSYERR] = busyerr;
      csr_pack[CSR_BUSERR] = buserr;
      csr_pack[CSR_BUSY] = busy;
      csr_pack[CSR_AINCR] = aincr;
   endfunction
endpackage

// File: rtl/twowire_dtm_cmd_engine_if.sv
// twowire_dtm_cmd_engine_if: word-access req/ack debug bus between the command engine and the fabric
interface twowire_dtm_cmd_engine_if;
   logic        bus_req;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic        bus_err;
   logic [31:0] bus_rdata;

   modport master (output bus_req, bus_write, bus_addr, bus_wdata,
                   input  bus_ack, bus_err, bus_rdata);
   modport slave  (input  bus_req, bus_write, bus_addr, bus_wdata,
                   output bus_ack, bus_err, bus_rdata);
endinterface

// File: rtl/twowire_dtm_cmd_engine_bus_master.sv
// twowire_dtm_bus_master: issues one word access at a time, owns ADDR, rbuf and the CSR flags
module twowire_dtm_bus_master
   import twowire_dtm_cmd_engine_pkg::*;
(
   input  logic        dck,
   input  logic        drst_n,
   input  logic        rd_start,
   input  logic        wr_start,
   input  logic [31:0] wr_data,
   input  logic        addr_wr,
   input  logic [29:0] addr_word,
   input  logic        csr_wr,
   input  logic        clr_busyerr,
   input  logic        clr_buserr,
   input  logic        aincr_in,
   output logic [31:0] addr,
   output logic [31:0] rbuf,
   output logic        busyerr,
   output logic        buserr,
   output logic        aincr,
   output logic        busy,
   twowire_dtm_cmd_engine_if.master bus
);
   bus_state_t  state, state_nx;
   logic        write_q;
   logic [31:0] addr_q, wdata_q;
   logic        start, issue, done;

   assign start = rd_start | wr_start;
   assign busy  = state == BUS_WAIT;
   assign issue = start & ~busy & ~busyerr;
   assign done  = busy & bus.bus_ack;

   assign bus.bus_req   = busy;
   assign bus.bus_write = write_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;

   always_comb begin
      state_nx = state;
      if (issue) state_nx = BUS_WAIT;
      else if (done) state_nx = BUS_IDLE;
   end

   // sticky flags: a new set in the same cycle as a W1C clear wins
   always_ff @(posedge dck or negedge drst_n) begin
      if (!drst_n) begin
         state   <= BUS_IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         addr    <= '0;
         rbuf    <= '0;
         busyerr <= 1'b0;
         buserr  <= 1'b0;
         aincr   <= 1'b0;
      end else begin
         state <= state_nx;
         if (issue) begin
            write_q <= wr_start;
            addr_q  <= addr;
            if (wr_start) wdata_q <= wr_data;
         end
         if (addr_wr) addr <= {addr_word, 2'b00};
         else if (issue && aincr) addr <= addr + 32'd4;
         if (done && !write_q) rbuf <= bus.bus_rdata;
         busyerr <= (start & ~issue) | (busyerr & ~(csr_wr & clr_busyerr));
         buserr  <= (done & bus.bus_err) | (buserr & ~(csr_wr & clr_buserr));
         if (csr_wr) aincr <= aincr_in;
      end
   end
endmodule

// File: rtl/twowire_dtm_cmd_engine.sv
// twowire_dtm_cmd_engine: decodes DTM commands, shifts payload bits LSB first, commits writes
module twowire_dtm_cmd_engine
   import twowire_dtm_cmd_engine_pkg::*;
#(
   parameter logic [31:0] IDCODE = 32'h0000_0001,
   parameter int          W_CMD  = 4
) (
   input  logic             dck,
   input  logic             drst_n,
   input  logic             connected,
   input  logic [W_CMD-1:0] cmd,
   input  logic             cmd_vld,
   output logic             cmd_payload_end,
   input  logic             parity_err,
   input  logic             wdata,
   input  logic             wdata_vld,
   output logic             rdata,
   input  logic             rdata_rdy,
   output logic             disconnect_req,
   twowire_dtm_cmd_engine_if.master bus
);
   state_t           state, state_nx;
   logic [W_CMD-1:0] op;
   logic [4:0]       bitcnt;
   logic [31:0]      wsreg, rsreg, src, addr, rbuf;
   logic             go, beat, last, commit;
   logic             busyerr, buserr, aincr, busy;

   function automatic logic is_op(input logic [W_CMD-1:0] c, input logic [3:0] code);
      return c == W_CMD'(code);
   endfunction

   assign go     = cmd_vld & connected;
   assign beat   = wdata_vld | rdata_rdy;
   assign last   = bitcnt == (is_op(op, CMD_DISCONNECT) ? 5'(DISC_BITS - 1) : 5'(XFER_BITS - 1));
   assign commit = (state == COMMIT) & connected & ~parity_err;

   assign cmd_payload_end = (state == XFER) & beat & last;
   assign disconnect_req  = commit & is_op(op, CMD_DISCONNECT);
   assign rdata           = rsreg[0];

   // read source is chosen from the incoming command so it is captured on the cmd_vld edge
   assign src = is_op(cmd, CMD_R_IDCODE) ? IDCODE :
                is_op(cmd, CMD_R_CSR)    ? csr_pack(busyerr, buserr, busy, aincr) :
                is_op(cmd, CMD_R_ADDR)   ? addr :
                is_op(cmd, CMD_R_DATA)   ? rbuf : '0;

   always_comb begin
      state_nx = state;
      if (!connected) state_nx = IDLE;
      else if (cmd_vld) state_nx = XFER;
      else if (cmd_payload_end) state_nx = ^op ? IDLE : COMMIT;
      else if (state == COMMIT) state_nx = IDLE;
   end

   always_ff @(posedge dck or negedge drst_n) begin
      if (!drst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge dck or negedge drst_n) begin
      if (!drst_n) begin
         op     <= '0;
         bitcnt <= '0;
         wsreg  <= '0;
         rsreg  <= '0;
      end else if (go) begin
         op     <= cmd;
         bitcnt <= '0;
         if (^cmd) rsreg <= src;
      end else if (state == XFER) begin
         if (beat) bitcnt <= bitcnt + 5'd1;
         if (wdata_vld) wsreg <= {wdata, wsreg[31:1]};
         if (rdata_rdy) rsreg <= {1'b0, rsreg[31:1]};
      end
   end

   twowire_dtm_bus_master u_bus_master (
      .dck         (dck),
      .drst_n      (drst_n),
      .rd_start    (go & is_op(cmd, CMD_R_DATA)),
      .wr_start    (commit & is_op(op, CMD_W_DATA)),
      .wr_data     (wsreg),
      .addr_wr     (commit & is_op(op, CMD_W_ADDR)),
      .addr_word   (wsreg[31:2]),
      .csr_wr      (commit & is_op(op, CMD_W_CSR)),
      .clr_busyerr (wsreg[CSR_BUSYERR]),
      .clr_buserr  (wsreg[CSR_BUSERR]),
      .aincr_in    (wsreg[CSR_AINCR]),
      .addr        (addr),
      .rbuf        (rbuf),
      .busyerr     (busyerr),
      .buserr      (buserr),
      .aincr       (aincr),
      .busy        (busy),
      .bus         (bus)
   );
endmodule

// File: tb/tb_twowire_dtm_cmd_engine.sv
// tb_twowire_dtm_cmd_engine: scoreboarded bench for the DTM command engine and its bus master
module tb_twowire_dtm_cmd_engine;
   import twowire_dtm_cmd_engine_pkg::*;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_txn_t;

   logic        dck, drst_n, connected, cmd_vld, cmd_payload_end, parity_err;
   logic        wdata, wdata_vld, rdata, rdata_rdy, disconnect_req;
   logic [3:0]  cmd;
   int          n_chk, n_pass;
   int          ack_dly, wait_cnt, collide_req, collide_done;
   bit          manual, err_next;
   logic [31:0] rd_val;
   logic [31:0] exp_q[$];
   bus_txn_t    bus_q[$];

   twowire_dtm_cmd_engine_if bus ();

   twowire_dtm_cmd_engine #(.IDCODE(32'h0000_0001), .W_CMD(4)) dut (
      .dck             (dck),
      .drst_n          (drst_n),
      .connected       (connected),
      .cmd             (cmd),
      .cmd_vld         (cmd_vld),
      .cmd_payload_end (cmd_payload_end),
      .parity_err      (parity_err),
      .wdata           (wdata),
      .wdata_vld       (wdata_vld),
      .rdata           (rdata),
      .rdata_rdy       (rdata_rdy),
      .disconnect_req  (disconnect_req),
      .bus             (bus)
   );

   initial dck = 1'b0;
   always #5 dck = ~dck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic check_bus();
      bus_txn_t t;
      if (bus_q.size() == 0) begin
         chk("bus_unexpected_req", 32'(bus.bus_req), 32'd0);
         return;
      end
      t = bus_q.pop_front();
      chk("bus_write", 32'(bus.bus_write), 32'(t.write));
      chk("bus_addr", bus.bus_addr, t.addr);
      if (t.write) chk("bus_wdata", bus.bus_wdata, t.data);
   endtask

   task automatic push_bus(input logic w, input logic [31:0] a, input logic [31:0] d);
      bus_txn_t t;
      t.write = w;
      t.addr = a;
      t.data = d;
      bus_q.push_back(t);
   endtask

   // all stimulus tasks start and end on a falling edge
   task automatic send_cmd(input logic [3:0] c);
      cmd = c;
      cmd_vld = 1'b1;
      @(negedge dck);
      cmd_vld = 1'b0;
   endtask

   task automatic read_word(input logic [3:0] c, input logic [31:0] exp, input bit check_end);
      logic [31:0] w;
      w = '0;
      exp_q.push_back(exp);
      send_cmd(c);
      for (int i = 0; i < 32; i++) begin
         rdata_rdy = 1'b1;
         #1;
         w[i] = rdata;
         if (check_end) chk($sformatf("payload_end_bit%0d", i), 32'(cmd_payload_end), 32'(i == 31));
         @(negedge dck);
      end
      rdata_rdy = 1'b0;
      chk($sformatf("read_cmd%0d", c), w, exp_q.pop_front());
   endtask

   task automatic write_word(input logic [3:0] c, input logic [31:0] d, input int nbits,
                             input bit bad, input int drop_at, input bit collide);
      send_cmd(c);
      for (int i = 0; i < nbits; i++) begin
         wdata = d[i];
         wdata_vld = 1'b1;
         if (i == drop_at) connected = 1'b0;
         if (collide && i == nbits - 1) begin
            #2;
            collide_req++;
         end
         @(negedge dck);
         if (i == drop_at) begin
            connected = 1'b1;
            wdata_vld = 1'b0;
            return;
         end
      end
      wdata_vld = 1'b0;
      parity_err = bad;
      #1;
      chk($sformatf("disconnect_req_cmd%0d", c), 32'(disconnect_req), 32'(c == 4'h0 && !bad));
      @(negedge dck);
      parity_err = 1'b0;
   endtask

   task automatic wr(input logic [3:0] c, input logic [31:0] d);
      write_word(c, d, 32, 1'b0, -1, 1'b0);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 500 && bus.bus_req; n++) @(negedge dck);
      chk("bus_idle", 32'(bus.bus_req), 32'd0);
   endtask

   // bus slave: acks after ack_dly cycles, or once on request from a collision frame
   initial begin
      bus.bus_ack = 1'b0;
      bus.bus_err = 1'b0;
      bus.bus_rdata = '0;
      wait_cnt = 0;
      collide_done = 0;
      forever begin
         @(negedge dck);
         bus.bus_ack = 1'b0;
         bus.bus_err = 1'b0;
         if (collide_req != collide_done) begin
            collide_done = collide_req;
            bus.bus_ack = 1'b1;
            bus.bus_err = 1'b1;
            bus.bus_rdata = 32'hA5A5_A5A5;
            check_bus();
         end else if (!manual && bus.bus_req) begin
            if (wait_cnt >= ack_dly) begin
               bus.bus_ack = 1'b1;
               bus.bus_err = err_next;
               bus.bus_rdata = rd_val;
               wait_cnt = 0;
               check_bus();
            end else wait_cnt++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_pass = 0;
      ack_dly = 0;
      collide_req = 0;
      manual = 1'b0;
      err_next = 1'b0;
      rd_val = '0;
      drst_n = 1'b0;
      connected = 1'b1;
      cmd = '0;
      cmd_vld = 1'b0;
      parity_err = 1'b0;
      wdata = 1'b0;
      wdata_vld = 1'b0;
      rdata_rdy = 1'b0;
      repeat (2) @(negedge dck);
      #1;
      chk("rst_flags", 32'({cmd_payload_end, rdata, disconnect_req, bus.bus_req, bus.bus_write}), 32'd0);
      chk("rst_bus_addr", bus.bus_addr, 32'd0);
      chk("rst_bus_wdata", bus.bus_wdata, 32'd0);
      @(negedge dck);
      drst_n = 1'b1;
      @(negedge dck);

      read_word(CMD_R_IDCODE, 32'h0000_0001, 1'b1);

      wr(CMD_W_ADDR, 32'h0000_1003);
      read_word(CMD_R_ADDR, 32'h0000_1000, 1'b0);
      write_word(CMD_W_ADDR, 32'h0000_2000, 32, 1'b1, -1, 1'b0);
      read_word(CMD_R_ADDR, 32'h0000_1000, 1'b0);

      wr(CMD_W_CSR, 32'h8);
      wr(CMD_W_ADDR, 32'hFFFF_FFFC);
      push_bus(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D);
      wr(CMD_W_DATA, 32'hCAFE_F00D);
      wait_idle();
      read_word(CMD_R_ADDR, 32'h0, 1'b0);
      read_word(CMD_R_CSR, 32'h1000_0008, 1'b0);
      wr(CMD_W_CSR, 32'h0);

      wr(CMD_W_ADDR, 32'h40);
      ack_dly = 100;
      rd_val = 32'h1234_5678;
      push_bus(1'b0, 32'h40, 32'h0);
      read_word(CMD_R_DATA, 32'h0, 1'b0);
      read_word(CMD_R_DATA, 32'h0, 1'b0);
      read_word(CMD_R_CSR, 32'h1000_0005, 1'b0);
      wait_idle();
      read_word(CMD_R_CSR, 32'h1000_0001, 1'b0);
      wr(CMD_W_CSR, 32'h1);
      read_word(CMD_R_CSR, 32'h1000_0000, 1'b0);
      ack_dly = 0;
      rd_val = 32'h9ABC_DEF0;
      push_bus(1'b0, 32'h40, 32'h0);
      read_word(CMD_R_DATA, 32'h1234_5678, 1'b0);
      wait_idle();

      err_next = 1'b1;
      push_bus(1'b1, 32'h40, 32'h55);
      wr(CMD_W_DATA, 32'h55);
      wait_idle();
      err_next = 1'b0;
      read_word(CMD_R_CSR, 32'h1000_0002, 1'b0);

      manual = 1'b1;
      push_bus(1'b0, 32'h40, 32'h0);
      read_word(CMD_R_DATA, 32'h9ABC_DEF0, 1'b0);
      write_word(CMD_W_CSR, 32'h2, 32, 1'b0, -1, 1'b1);
      manual = 1'b0;
      read_word(CMD_R_CSR, 32'h1000_0002, 1'b0);
      wr(CMD_W_CSR, 32'h2);
      read_word(CMD_R_CSR, 32'h1000_0000, 1'b0);

      write_word(CMD_W_CSR, 32'h8, 32, 1'b0, 10, 1'b0);
      read_word(CMD_R_CSR, 32'h1000_0000, 1'b0);
      read_word(4'h8, 32'h0, 1'b0);
      wr(4'h9, 32'hFFFF_FFFF);
      read_word(CMD_R_CSR, 32'h1000_0000, 1'b0);

      write_word(CMD_DISCONNECT, 32'hAB, 8, 1'b0, -1, 1'b0);
      write_word(CMD_DISCONNECT, 32'hAB, 8, 1'b1, -1, 1'b0);

      manual = 1'b1;
      push_bus(1'b0, 32'h40, 32'h0);
      send_cmd(CMD_R_DATA);
      #1;
      chk("pre_rst_rdata", 32'(rdata), 32'd1);
      chk("pre_rst_bus_req", 32'(bus.bus_req), 32'd1);
      check_bus();
      #1;
      drst_n = 1'b0;
      #1;
      chk("mid_rst_flags", 32'({cmd_payload_end, rdata, disconnect_req, bus.bus_req, bus.bus_write}), 32'd0);
      chk("mid_rst_bus_addr", bus.bus_addr, 32'd0);
      chk("mid_rst_bus_wdata", bus.bus_wdata, 32'd0);
      @(negedge dck);
      drst_n = 1'b1;
      manual = 1'b0;
      @(negedge dck);
      chk("bus_q_empty", 32'(bus_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
